// File: rtl/matvec_pe_con_pkg.sv
// Shared types and helpers for the BRAM-mastered matrix-vector controller.
package matvec_pe_con_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_VEC,
    ST_CLR,
    ST_MAC,
    ST_DRAIN,
    ST_WR,
    ST_DONE
  } state_e;

  localparam logic [3:0] BRAM_WE_ALL  = 4'hF;
  localparam logic [3:0] BRAM_WE_NONE = 4'h0;

  function automatic logic [31:0] word2byte(input logic [31:0] w);
    return {w[29:0], 2'b00};
  endfunction

  // Accumulators are sign-extended to 64 bits before clamping to signed 32-bit.
  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/matvec_pe_con_mac_lane.sv
// One MAC lane: registered accumulator with synchronous clear and enable.
module pe_mac_lane #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matvec_pe_con.sv
// Matrix-vector controller: loads v, streams M row-major into NUM_PE MAC lanes,
// writes saturated (optionally ReLU'd) y back to BRAM.
module matvec_pe_con
  import matvec_pe_con_pkg::*;
#(
  parameter int unsigned VECTOR_SIZE = 64,
  parameter int unsigned L_RAM_SIZE  = 6,
  parameter int unsigned NUM_ROWS    = 64,
  parameter int unsigned NUM_PE      = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned VEC_BASE    = 0,
  parameter int unsigned MAT_BASE    = VECTOR_SIZE,
  parameter int unsigned OUT_BASE    = VECTOR_SIZE * (NUM_ROWS + 1)
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        relu_en,
  output logic        busy,
  output logic        done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  output logic        BRAM_CLK,
  input  logic [31:0] BRAM_RDDATA
);

  localparam int unsigned G  = NUM_ROWS / NUM_PE;
  localparam int unsigned KW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int unsigned LW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned VDEPTH = 2 ** L_RAM_SIZE;

  localparam logic [KW-1:0] K_LAST = KW'(VECTOR_SIZE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(NUM_PE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [2:0]    W_LAST = 3'(RD_LATENCY - 1);

  typedef struct packed {
    logic          vld;
    logic          vec;
    logic [LW-1:0] lane;
    logic [KW-1:0] k;
  } tag_t;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [GW-1:0] g_q, g_d;
  logic [2:0]    wt_q, wt_d;
  logic          issued_q, issued_d;
  logic          relu_q, relu_d;

  logic          rd_issue, rd_vec, acc_clr;
  logic [31:0]   addr_word, wr_word;
  logic [3:0]    we;

  tag_t          tag_q [RD_LATENCY];
  tag_t          ret;
  logic signed [DATA_WIDTH-1:0] vbuf_q [VDEPTH];
  logic [L_RAM_SIZE-1:0]        vidx;
  logic signed [DATA_WIDTH-1:0] rd_op, vb_op;

  logic signed [ACC_WIDTH-1:0]  lane_acc [NUM_PE];
  logic [NUM_PE-1:0]            lane_en;
  logic signed [ACC_WIDTH-1:0]  acc_sel;
  logic [31:0]                  sat_w;
  logic                         unused_rd_hi;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lane_d    = lane_q;
    g_d       = g_q;
    wt_d      = wt_q;
    issued_d  = issued_q;
    relu_d    = relu_q;
    rd_issue  = 1'b0;
    rd_vec    = 1'b0;
    acc_clr   = 1'b0;
    addr_word = '0;
    we        = BRAM_WE_NONE;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_LD_VEC;
          k_d      = '0;
          lane_d   = '0;
          g_d      = '0;
          wt_d     = '0;
          issued_d = 1'b0;
          relu_d   = relu_en;
        end
      end
      // Issue VECTOR_SIZE reads, then hold RD_LATENCY cycles for the tail to land.
      ST_LD_VEC: begin
        if (!issued_q) begin
          rd_issue  = 1'b1;
          rd_vec    = 1'b1;
          addr_word = 32'(VEC_BASE) + 32'(k_q);
          if (k_q == K_LAST) begin
            k_d      = '0;
            issued_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else if (wt_q == W_LAST) begin
          wt_d    = '0;
          state_d = ST_CLR;
        end else begin
          wt_d = wt_q + 1'b1;
        end
      end
      ST_CLR: begin
        acc_clr = 1'b1;
        k_d     = '0;
        lane_d  = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        rd_issue  = 1'b1;
        addr_word = 32'(MAT_BASE)
                  + (32'(g_q) * 32'(NUM_PE) + 32'(lane_q)) * 32'(VECTOR_SIZE)
                  + 32'(k_q);
        if (lane_q == L_LAST) begin
          lane_d = '0;
          if (k_q == K_LAST) begin
            k_d     = '0;
            wt_d    = '0;
            state_d = ST_DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wt_q == W_LAST) begin
          wt_d    = '0;
          lane_d  = '0;
          state_d = ST_WR;
        end else begin
          wt_d = wt_q + 1'b1;
        end
      end
      ST_WR: begin
        we        = BRAM_WE_ALL;
        addr_word = 32'(OUT_BASE) + 32'(g_q) * 32'(NUM_PE) + 32'(lane_q);
        if (lane_q == L_LAST) begin
          lane_d = '0;
          if (g_q == G_LAST) begin
            g_d     = '0;
            state_d = ST_DONE;
          end else begin
            g_d     = g_q + 1'b1;
            state_d = ST_CLR;
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      lane_q   <= '0;
      g_q      <= '0;
      wt_q     <= '0;
      issued_q <= 1'b0;
      relu_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      lane_q   <= lane_d;
      g_q      <= g_d;
      wt_q     <= wt_d;
      issued_q <= issued_d;
      relu_q   <= relu_d;
    end
  end

  // Each issued read carries its destination; the oldest tag lines up with BRAM_RDDATA.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: rd_issue, vec: rd_vec, lane: lane_q, k: k_q};
      for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret          = tag_q[RD_LATENCY-1];
  assign rd_op        = BRAM_RDDATA[DATA_WIDTH-1:0];
  assign vidx         = L_RAM_SIZE'(ret.k);
  assign vb_op        = vbuf_q[vidx];
  assign unused_rd_hi = ^BRAM_RDDATA[31:DATA_WIDTH];

  always_ff @(posedge aclk) begin
    if (ret.vld && ret.vec) vbuf_q[vidx] <= rd_op;
  end

  for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
    assign lane_en[p] = ret.vld && !ret.vec && (ret.lane == LW'(p));
    pe_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk_i  (aclk),
      .rst_ni (aresetn),
      .clr_i  (acc_clr),
      .en_i   (lane_en[p]),
      .a_i    (rd_op),
      .b_i    (vb_op),
      .acc_o  (lane_acc[p])
    );
  end

  always_comb begin
    acc_sel = '0;
    for (int unsigned p = 0; p < NUM_PE; p++) begin
      if (lane_q == LW'(p)) acc_sel = lane_acc[p];
    end
  end

  assign sat_w   = sat32(64'(acc_sel));
  assign wr_word = (relu_q && sat_w[31]) ? '0 : sat_w;

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign BRAM_ADDR   = word2byte(addr_word);
  assign BRAM_WRDATA = (state_q == ST_WR) ? wr_word : '0;
  assign BRAM_WE     = we;
  assign BRAM_CLK    = aclk;

endmodule

// File: tb/tb_matvec_pe_con.sv
// Directed bench for matvec_pe_con: default build plus NUM_PE=8/RD_LATENCY=4 and NUM_PE=1/RD_LATENCY=1 builds.
module tb_matvec_pe_con;

  localparam int OA = 64 * 65, SZA = OA + 64;
  localparam int VB = 8, RB = 16, PB = 8, LB = 4, OB = VB * (RB + 1), SZB = OB + RB;
  localparam int VC = 8, RC = 4,  PC = 1, LC = 1, OC = VC * (RC + 1), SZC = OC + RC;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic start_a, relu_a, busy_a, done_a, bclk_a;
  logic start_b, relu_b, busy_b, done_b, bclk_b;
  logic start_c, relu_c, busy_c, done_c, bclk_c;
  logic [31:0] addr_a, wdata_a, rd_a, addr_b, wdata_b, rd_b, addr_c, wdata_c, rd_c;
  logic [3:0]  we_a, we_b, we_c;

  int n_cmp = 0, n_bad = 0;

  matvec_pe_con dut_a (
    .aclk(clk), .aresetn(rst_n), .start(start_a), .relu_en(relu_a), .busy(busy_a), .done(done_a),
    .BRAM_ADDR(addr_a), .BRAM_WRDATA(wdata_a), .BRAM_WE(we_a), .BRAM_CLK(bclk_a), .BRAM_RDDATA(rd_a));

  matvec_pe_con #(
    .VECTOR_SIZE(VB), .L_RAM_SIZE(3), .NUM_ROWS(RB), .NUM_PE(PB), .DATA_WIDTH(16), .ACC_WIDTH(40),
    .RD_LATENCY(LB), .VEC_BASE(0), .MAT_BASE(VB), .OUT_BASE(OB)
  ) dut_b (
    .aclk(clk), .aresetn(rst_n), .start(start_b), .relu_en(relu_b), .busy(busy_b), .done(done_b),
    .BRAM_ADDR(addr_b), .BRAM_WRDATA(wdata_b), .BRAM_WE(we_b), .BRAM_CLK(bclk_b), .BRAM_RDDATA(rd_b));

  matvec_pe_con #(
    .VECTOR_SIZE(VC), .L_RAM_SIZE(3), .NUM_ROWS(RC), .NUM_PE(PC), .DATA_WIDTH(16), .ACC_WIDTH(40),
    .RD_LATENCY(LC), .VEC_BASE(0), .MAT_BASE(VC), .OUT_BASE(OC)
  ) dut_c (
    .aclk(clk), .aresetn(rst_n), .start(start_c), .relu_en(relu_c), .busy(busy_c), .done(done_c),
    .BRAM_ADDR(addr_c), .BRAM_WRDATA(wdata_c), .BRAM_WE(we_c), .BRAM_CLK(bclk_c), .BRAM_RDDATA(rd_c));

  // BRAM models; a one-cycle fill loads the pattern and clears the write statistics.
  logic [31:0] mem_a [SZA], mem_b [SZB], mem_c [SZC];
  logic [31:0] rp_a [2], rp_b [LB], rp_c [LC];
  logic [31:0] rv_b [VB], rm_b [RB*VB], rv_c [VC], rm_c [RC*VC];
  logic fill_a, fill_b, fill_c;
  int vsel_a, msel_a;
  int we_cnt_a, bad_a, we_cnt_b, bad_b, we_cnt_c, bad_c;

  function automatic logic [31:0] word_a(input int i);
    logic [15:0] v;
    if (i < 64) begin
      case (vsel_a)
        0: v = 16'd1;
        1: v = 16'hFFFF;
        2: v = 16'h7FFF;
        default: v = 16'(i - 32);
      endcase
    end else if (i < OA) begin
      case (msel_a)
        0: v = 16'((i - 64) / 64);
        1: v = 16'd1;
        default: v = 16'h7FFF;
      endcase
    end else begin
      return 32'hDEAD_BEEF;
    end
    return {16'hA5A5, v};
  endfunction

  always @(posedge clk) begin
    rp_a[0] <= mem_a[addr_a[31:2]];
    rp_a[1] <= rp_a[0];
    if (fill_a) begin
      for (int i = 0; i < SZA; i++) mem_a[i] <= word_a(i);
      we_cnt_a <= 0; bad_a <= 0;
    end else if (we_a == 4'hF) begin
      mem_a[addr_a[31:2]] <= wdata_a;
      we_cnt_a <= we_cnt_a + 1;
      if (addr_a[31:2] < 30'(OA) || addr_a[31:2] >= 30'(SZA)) bad_a <= bad_a + 1;
    end else if (we_a != 4'h0) bad_a <= bad_a + 1;
  end

  always @(posedge clk) begin
    rp_b[0] <= mem_b[addr_b[31:2]];
    for (int i = 1; i < LB; i++) rp_b[i] <= rp_b[i-1];
    if (fill_b) begin
      for (int i = 0; i < SZB; i++)
        mem_b[i] <= (i < VB) ? rv_b[i] : (i < OB) ? rm_b[i-VB] : 32'hDEAD_BEEF;
      we_cnt_b <= 0; bad_b <= 0;
    end else if (we_b == 4'hF) begin
      mem_b[addr_b[31:2]] <= wdata_b;
      we_cnt_b <= we_cnt_b + 1;
      if (addr_b[31:2] < 30'(OB) || addr_b[31:2] >= 30'(SZB)) bad_b <= bad_b + 1;
    end else if (we_b != 4'h0) bad_b <= bad_b + 1;
  end

  always @(posedge clk) begin
    rp_c[0] <= mem_c[addr_c[31:2]];
    if (fill_c) begin
      for (int i = 0; i < SZC; i++)
        mem_c[i] <= (i < VC) ? rv_c[i] : (i < OC) ? rm_c[i-VC] : 32'hDEAD_BEEF;
      we_cnt_c <= 0; bad_c <= 0;
    end else if (we_c == 4'hF) begin
      mem_c[addr_c[31:2]] <= wdata_c;
      we_cnt_c <= we_cnt_c + 1;
      if (addr_c[31:2] < 30'(OC) || addr_c[31:2] >= 30'(SZC)) bad_c <= bad_c + 1;
    end else if (we_c != 4'h0) bad_c <= bad_c + 1;
  end

  assign rd_a = rp_a[1];
  assign rd_b = rp_b[LB-1];
  assign rd_c = rp_c[LC-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
  endfunction

  function automatic logic [31:0] sat_relu(input longint s, input logic relu);
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    if (relu && s < 0) s = 0;
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_y(input int w, input int r, input logic relu);
    longint s = 0;
    logic signed [15:0] m, v;
    int n = (w == 1) ? VB : VC;
    for (int k = 0; k < n; k++) begin
      m = (w == 1) ? rm_b[r*VB+k][15:0] : rm_c[r*VC+k][15:0];
      v = (w == 1) ? rv_b[k][15:0] : rv_c[k][15:0];
      s = s + longint'(m) * longint'(v);
    end
    return sat_relu(s, relu);
  endfunction

  function automatic logic [31:0] exp_a(input int mode, input int r);
    case (mode)
      0: return 32'(64 * r);
      1: return 32'h0;
      2: return 32'hFFFF_FFC0;
      3: return 32'h7FFF_FFFF;
      default: return 32'(-32 * r);
    endcase
  endfunction

  task automatic fill(input int w);
    @(negedge clk);
    fill_a = (w == 0); fill_b = (w == 1); fill_c = (w == 2);
    @(negedge clk);
    fill_a = 1'b0; fill_b = 1'b0; fill_c = 1'b0;
  endtask

  // Pulses start, optionally re-pulses start at cycle inject or aborts with reset at cycle abort.
  task automatic run(input int w, input logic relu, input int inject, input int abort,
                     input int exp_cyc, input string tag);
    int cyc;
    @(negedge clk);
    start_a = (w == 0); start_b = (w == 1); start_c = (w == 2);
    relu_a = relu; relu_b = relu; relu_c = relu;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cyc = 1;
    chk({tag, ".busy_hi"}, 32'(busy_of(w)), 32'd1);
    chk({tag, ".done_lo"}, 32'(done_of(w)), 32'd0);
    while (!done_of(w) && cyc < 20000) begin
      if (cyc == abort) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_busy"}, 32'(busy_a), 32'd0);
        chk({tag, ".rst_done"}, 32'(done_a), 32'd0);
        chk({tag, ".rst_we"},   32'(we_a),   32'd0);
        chk({tag, ".rst_addr"}, addr_a,      32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start_a = (w == 0) && (cyc == inject);
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    chk({tag, ".cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic check_a(input string tag, input int mode);
    for (int r = 0; r < 64; r++) chk({tag, ".y"}, mem_a[OA+r], exp_a(mode, r));
    chk({tag, ".we_cnt"}, 32'(we_cnt_a), 32'd64);
    chk({tag, ".we_bad"}, 32'(bad_a), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    {start_a, start_b, start_c, relu_a, relu_b, relu_c} = '0;
    {fill_a, fill_b, fill_c} = '0;
    vsel_a = 0; msel_a = 0;
    repeat (3) @(negedge clk);
    chk("reset.busy",  32'(busy_a), 32'd0);
    chk("reset.done",  32'(done_a), 32'd0);
    chk("reset.addr",  addr_a,      32'd0);
    chk("reset.wdata", wdata_a,     32'd0);
    chk("reset.we",    32'(we_a),   32'd0);
    rst_n = 1'b1;

    vsel_a = 0; msel_a = 0; fill(0);
    run(0, 1'b0, -1, -1, 4275, "T1");
    check_a("T1", 0);

    vsel_a = 1; msel_a = 1; fill(0);
    run(0, 1'b1, -1, -1, 4275, "T2r");
    check_a("T2r", 1);
    fill(0);
    run(0, 1'b0, -1, -1, 4275, "T2n");
    check_a("T2n", 2);

    vsel_a = 2; msel_a = 2; fill(0);
    run(0, 1'b0, -1, -1, 4275, "T3");
    check_a("T3", 3);

    for (int i = 0; i < VB; i++)    rv_b[i] = $urandom();
    for (int i = 0; i < RB*VB; i++) rm_b[i] = $urandom();
    for (int i = 0; i < VC; i++)    rv_c[i] = $urandom();
    for (int i = 0; i < RC*VC; i++) rm_c[i] = $urandom();
    fill(1); fill(2);
    run(1, 1'b1, -1, -1, 167, "T4b");
    for (int r = 0; r < RB; r++) chk("T4b.y", mem_b[OB+r], ref_y(1, r, 1'b1));
    chk("T4b.we_cnt", 32'(we_cnt_b), 32'(RB));
    chk("T4b.we_bad", 32'(bad_b), 32'd0);
    run(2, 1'b0, -1, -1, 54, "T4c");
    for (int r = 0; r < RC; r++) chk("T4c.y", mem_c[OC+r], ref_y(2, r, 1'b0));
    chk("T4c.we_cnt", 32'(we_cnt_c), 32'(RC));
    chk("T4c.we_bad", 32'(bad_c), 32'd0);

    vsel_a = 0; msel_a = 0; fill(0);
    run(0, 1'b0, 168, -1, 4275, "T5s");
    check_a("T5s", 0);
    fill(0);
    run(0, 1'b0, -1, 200, 0, "T5a");
    fill(0);
    run(0, 1'b0, -1, -1, 4275, "T5f");
    check_a("T5f", 0);

    vsel_a = 3; msel_a = 0; fill(0);
    chk("T6.done_before", 32'(done_a), 32'd1);
    run(0, 1'b0, -1, -1, 4275, "T6");
    check_a("T6", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
